receptor_serial7b: RTL and testbench

Serial-in/parallel-out receiver for the 7-bit serial link driven by the team's 7-bit shift-register transmitter. The transmitter shifts its register toward bit 0, so the line carries data LSB first. This block detects the start bit and shifts in 7 data bits on each bit strobe. It checks the stop bit, then presents the word on a parallel output held under a valid/acknowledge handshake to the consuming logic.

---
 rtl/serial7b_pkg.sv | 18 +
 rtl/contador_bits7b.sv | 28 ++
 rtl/receptor_serial7b.sv | 121 ++++++++++++
 tb/tb_receptor_serial7b.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/serial7b_pkg.sv
// Shared definitions for the 7-bit serial link (transmitter and receiver).
package serial7b_pkg;

  // Data bits per frame
  localparam int unsigned LARGURA_QUADRO = 7;

  // Line level while idle; a stop bit carries the same level
  localparam logic LINHA_OCIOSA = 1'b1;

  // Receiver frame states
  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    DADOS    = 2'd1,
    PARIDADE = 2'd2,
    PARADA   = 2'd3
  } estado_rx_t;

endpackage

// File: rtl/contador_bits7b.sv
// 3-bit strobe-enabled bit counter with synchronous clear.
// 'terminal' flags the count at which the next strobe takes the last data bit.
module contador_bits7b
  import serial7b_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic terminal
);

  logic [2:0] contagem_q;

  // Count strobes; clear has priority over the enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      contagem_q <= 3'd0;
    end else if (clr) begin
      contagem_q <= 3'd0;
    end else if (en) begin
      contagem_q <= contagem_q + 3'd1;
    end
  end

  assign terminal = (contagem_q == 3'(LARGURA_QUADRO - 1));

endmodule

// File: rtl/receptor_serial7b.sv
// Serial-in/parallel-out receiver for the 7-bit LSB-first serial link.
// Frame: start (0), 7 data bits, [even parity], stop (1).
// Optional parity stage enabled by defining RECEPTOR_PARIDADE_EN.
module receptor_serial7b
  import serial7b_pkg::*;
#(
  parameter int unsigned LARGURA = LARGURA_QUADRO
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               serial_in,
  input  logic               sinal,
  input  logic               ack,
  output logic [LARGURA-1:0] dado,
  output logic               valido,
  output logic               erro_quadro,
`ifdef RECEPTOR_PARIDADE_EN
  output logic               erro_paridade,
`endif
  output logic               sobrecarga,
  output logic               ocupado
);

  estado_rx_t         estado_q;
  logic [LARGURA-1:0] sreg_q;
  logic               ultimo_bit;
  logic               cnt_clr;
  logic               cnt_en;
  logic               paridade_ok;
  logic               parada_ok;
  logic               conclui;

`ifdef RECEPTOR_PARIDADE_EN
  logic paridade_q;
  // Even parity: data plus parity bit must hold an even number of ones
  assign paridade_ok = ~(^{sreg_q, paridade_q});
`else
  assign paridade_ok = 1'b1;
`endif

  // Counter restarts whenever a start bit is seen in OCIOSO
  assign cnt_clr = (estado_q == OCIOSO) && sinal && (serial_in != LINHA_OCIOSA);
  assign cnt_en  = (estado_q == DADOS) && sinal;

  contador_bits7b u_contador (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .terminal (ultimo_bit)
  );

  assign parada_ok = (serial_in == LINHA_OCIOSA);
  assign conclui   = (estado_q == PARADA) && sinal && parada_ok && paridade_ok;
  assign ocupado   = (estado_q != OCIOSO);

  // Frame FSM, shift register and registered handshake/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q    <= OCIOSO;
      sreg_q      <= '0;
      dado        <= '0;
      valido      <= 1'b0;
      erro_quadro <= 1'b0;
      sobrecarga  <= 1'b0;
`ifdef RECEPTOR_PARIDADE_EN
      paridade_q    <= 1'b0;
      erro_paridade <= 1'b0;
`endif
    end else begin
      erro_quadro <= 1'b0;
`ifdef RECEPTOR_PARIDADE_EN
      erro_paridade <= 1'b0;
`endif

      if (sinal) begin
        unique case (estado_q)
          OCIOSO: begin
            if (serial_in != LINHA_OCIOSA) estado_q <= DADOS;
          end
          DADOS: begin
            sreg_q <= {serial_in, sreg_q[LARGURA-1:1]};
            if (ultimo_bit) begin
`ifdef RECEPTOR_PARIDADE_EN
              estado_q <= PARIDADE;
`else
              estado_q <= PARADA;
`endif
            end
          end
          PARIDADE: begin
`ifdef RECEPTOR_PARIDADE_EN
            paridade_q <= serial_in;
`endif
            estado_q <= PARADA;
          end
          PARADA: begin
            if (!parada_ok) erro_quadro <= 1'b1;
`ifdef RECEPTOR_PARIDADE_EN
            if (!paridade_ok) erro_paridade <= 1'b1;
`endif
            estado_q <= OCIOSO;
          end
          default: estado_q <= OCIOSO;
        endcase
      end

      // A completing word wins over ack; with ack on the same edge the old word
      // counts as consumed, so sobrecarga is left alone
      if (conclui) begin
        dado   <= sreg_q;
        valido <= 1'b1;
        if (valido && !ack) sobrecarga <= 1'b1;
      end else if (ack && valido) begin
        valido     <= 1'b0;
        sobrecarga <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_receptor_serial7b.sv
// Directed self-checking bench for receptor_serial7b.
module tb_receptor_serial7b;

  logic       clk;
  logic       rst;
  logic       serial_in;
  logic       sinal;
  logic       ack;
  logic [6:0] dado;
  logic       valido;
  logic       erro_quadro;
  logic       sobrecarga;
  logic       ocupado;
`ifdef RECEPTOR_PARIDADE_EN
  logic       erro_paridade;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  receptor_serial7b dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .sinal         (sinal),
    .ack           (ack),
    .dado          (dado),
    .valido        (valido),
    .erro_quadro   (erro_quadro),
`ifdef RECEPTOR_PARIDADE_EN
    .erro_paridade (erro_paridade),
`endif
    .sobrecarga    (sobrecarga),
    .ocupado       (ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One strobe carrying bit b; inputs change on falling edges, outputs read after
  task automatic strobe(input logic b, input logic a);
    @(negedge clk);
    serial_in = b;
    sinal     = 1'b1;
    ack       = a;
    @(negedge clk);
    sinal     = 1'b0;
    ack       = 1'b0;
    serial_in = 1'b1;
  endtask

  // Start bit plus 7 data bits, LSB first
  task automatic send_data(input logic [6:0] d);
    strobe(1'b0, 1'b0);
    for (int i = 0; i < 7; i++) strobe(d[i], 1'b0);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    serial_in = 1'b1;
    sinal     = 1'b0;
    ack       = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_dado", 32'(dado), 32'h0);
    chk("rst_valido", 32'(valido), 32'h0);
    chk("rst_erro", 32'(erro_quadro), 32'h0);
    chk("rst_sobre", 32'(sobrecarga), 32'h0);
    chk("rst_ocupado", 32'(ocupado), 32'h0);
    rst = 1'b0;

    // Reset mid-frame after 3 data bits, then a clean 0x2A frame
    strobe(1'b0, 1'b0);
    strobe(1'b1, 1'b0);
    strobe(1'b1, 1'b0);
    strobe(1'b1, 1'b0);
    chk("mid_ocupado", 32'(ocupado), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ocupado", 32'(ocupado), 32'h0);
    send_data(7'h2A);
    strobe(1'b1, 1'b0);
    chk("2a_dado", 32'(dado), 32'h2A);
    chk("2a_valido", 32'(valido), 32'h1);
    chk("2a_erro", 32'(erro_quadro), 32'h0);
    pulse_ack();
    chk("2a_ack", 32'(valido), 32'h0);

    // 0x55: valido only at the stop-bit edge
    send_data(7'h55);
    chk("55_latency", 32'(valido), 32'h0);
    chk("55_ocupado", 32'(ocupado), 32'h1);
    strobe(1'b1, 1'b0);
    chk("55_valido", 32'(valido), 32'h1);
    chk("55_dado", 32'(dado), 32'h55);
    chk("55_ocioso", 32'(ocupado), 32'h0);
    pulse_ack();
    chk("55_ack", 32'(valido), 32'h0);

    // 0x7F with bad stop bit: one-cycle erro_quadro, dado kept
    send_data(7'h7F);
    strobe(1'b0, 1'b0);
    chk("7f_erro", 32'(erro_quadro), 32'h1);
    chk("7f_dado", 32'(dado), 32'h55);
    chk("7f_valido", 32'(valido), 32'h0);
    @(negedge clk);
    chk("7f_erro_fim", 32'(erro_quadro), 32'h0);

    // Overrun: 0x01 then 0x40 without ack
    send_data(7'h01);
    strobe(1'b1, 1'b0);
    chk("01_sobre", 32'(sobrecarga), 32'h0);
    send_data(7'h40);
    strobe(1'b1, 1'b0);
    chk("40_dado", 32'(dado), 32'h40);
    chk("40_valido", 32'(valido), 32'h1);
    chk("40_sobre", 32'(sobrecarga), 32'h1);
    pulse_ack();
    chk("ack_valido", 32'(valido), 32'h0);
    chk("ack_sobre", 32'(sobrecarga), 32'h0);

    // Same pair, ack coincides with the second completion
    send_data(7'h01);
    strobe(1'b1, 1'b0);
    send_data(7'h40);
    strobe(1'b1, 1'b1);
    chk("40ack_dado", 32'(dado), 32'h40);
    chk("40ack_valido", 32'(valido), 32'h1);
    chk("40ack_sobre", 32'(sobrecarga), 32'h0);
    pulse_ack();
    chk("40ack_clear", 32'(valido), 32'h0);

    // Line low with no strobes: stays idle
    @(negedge clk);
    serial_in = 1'b0;
    repeat (20) @(negedge clk);
    chk("nostrobe_ocupado", 32'(ocupado), 32'h0);
    serial_in = 1'b1;

    // ack while nothing is pending changes nothing
    pulse_ack();
    chk("idle_ack_valido", 32'(valido), 32'h0);
    chk("idle_ack_dado", 32'(dado), 32'h40);

`ifdef RECEPTOR_PARIDADE_EN
    // 0x03 has two ones: parity 1 is wrong, parity 0 is right
    send_data(7'h03);
    strobe(1'b1, 1'b0);
    strobe(1'b1, 1'b0);
    chk("par_erro", 32'(erro_paridade), 32'h1);
    chk("par_valido", 32'(valido), 32'h0);
    chk("par_dado", 32'(dado), 32'h40);
    @(negedge clk);
    chk("par_erro_fim", 32'(erro_paridade), 32'h0);
    send_data(7'h03);
    strobe(1'b0, 1'b0);
    strobe(1'b1, 1'b0);
    chk("par_ok_erro", 32'(erro_paridade), 32'h0);
    chk("par_ok_valido", 32'(valido), 32'h1);
    chk("par_ok_dado", 32'(dado), 32'h03);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
